// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle main controller and the ALU decoder:
// state codes, datapath mux selects and instruction class codes.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10,
        S_MULSTART = 4'd11,
        S_MULWAIT  = 4'd12,
        S_MULWB    = 4'd13
    } state_t;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;
    localparam logic [1:0] RES_MUL     = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP       = 2'b00;
    localparam logic [1:0] OP_MEM      = 2'b01;
    localparam logic [1:0] OP_BR       = 2'b10;
    localparam logic [1:0] OP_ILL      = 2'b11;

endpackage

// File: rtl/mainfsm_hs_wait_timer.sv
// Watchdog for wait states: counts stalled cycles in the current state and
// flags expiry on the stalled cycle that brings the count to TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // cnt holds the number of earlier stalled cycles; it saturates at LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != LIMIT))
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT > 0) && en && (cnt >= LAST);

endmodule

// File: rtl/mainfsm_hs.sv
// Multicycle CPU main control FSM with memory ready handshake, a multi-cycle
// multiply path and a watchdog that aborts any stalled wait state.
module mainfsm_hs
    import mainfsm_pkg::*;
#(
    parameter bit          MUL_EN  = 1'b1,
    parameter bit          MEM_HS  = 1'b1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       is_mul,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       mul_start,
    output logic       bus_err,
    output logic [3:0] state_o
);

    // Handshake: an access is presented from the first cycle of FETCH, MEMREAD
    // or MEMWRITE and held unchanged until a cycle with mem_ready=1, which
    // completes it; with MEM_HS=0 every access completes in its first cycle.
    state_t state, state_next;
    logic   rdy;
    logic   waiting;
    logic   expired;
    logic   unused_funct;

    assign rdy          = mem_ready | ~MEM_HS;
    assign unused_funct = ^Funct[4:1];
    assign state_o      = state;

    always_comb begin
        waiting = 1'b0;
        case (state)
            S_FETCH, S_MEMREAD, S_MEMWRITE: waiting = ~rdy;
            S_MULWAIT:                      waiting = ~mul_done;
            default:                        waiting = 1'b0;
        endcase
    end

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_next != state),
        .en      (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_DP: begin
                        if (is_mul && MUL_EN) state_next = S_MULSTART;
                        else if (Funct[5])    state_next = S_EXECUTEI;
                        else                  state_next = S_EXECUTER;
                    end
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_UNKNOWN;
                endcase
            end
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (rdy) state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_MULSTART: state_next = S_MULWAIT;
            S_MULWAIT:  if (mul_done) state_next = S_MULWB;
            S_MULWB:    state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
        // expired implies the wait condition is unmet, so a met condition wins.
        if (expired) state_next = S_UNKNOWN;
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUOp     = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        mul_start = 1'b0;
        bus_err   = expired & ~reset;
        case (state)
            S_FETCH: begin
                IRWrite   = rdy & ~expired & ~reset;
                NextPC    = rdy & ~expired & ~reset;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_RDATA;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = ~expired;
            end
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
            end
            S_MULSTART: mul_start = 1'b1;
            S_MULWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_MUL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mainfsm_hs.sv
// Directed bench for mainfsm_hs: three instances (default, no-handshake with
// multiply disabled, short watchdog) share one stimulus set.
module tb_mainfsm_hs;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       is_mul;
    logic       mem_ready;
    logic       mul_done;

    logic       m_irw, m_npc, m_regw, m_memw, m_br, m_adr, m_aluop, m_mst, m_berr;
    logic [1:0] m_res, m_sa, m_sb;
    logic [3:0] m_state;
    logic       n_irw, n_npc, n_regw, n_memw, n_br, n_adr, n_aluop, n_mst, n_berr;
    logic [1:0] n_res, n_sa, n_sb;
    logic [3:0] n_state;
    logic       t_irw, t_npc, t_regw, t_memw, t_br, t_adr, t_aluop, t_mst, t_berr;
    logic [1:0] t_res, t_sa, t_sb;
    logic [3:0] t_state;

    int n_checks = 0;
    int n_bad    = 0;

    mainfsm_hs #(.MUL_EN(1'b1), .MEM_HS(1'b1), .TIMEOUT(16)) u_main (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .is_mul(is_mul),
        .mem_ready(mem_ready), .mul_done(mul_done),
        .IRWrite(m_irw), .NextPC(m_npc), .RegW(m_regw), .MemW(m_memw),
        .Branch(m_br), .AdrSrc(m_adr), .ALUOp(m_aluop), .ResultSrc(m_res),
        .ALUSrcA(m_sa), .ALUSrcB(m_sb), .mul_start(m_mst), .bus_err(m_berr),
        .state_o(m_state)
    );

    mainfsm_hs #(.MUL_EN(1'b0), .MEM_HS(1'b0), .TIMEOUT(16)) u_nohs (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .is_mul(is_mul),
        .mem_ready(mem_ready), .mul_done(mul_done),
        .IRWrite(n_irw), .NextPC(n_npc), .RegW(n_regw), .MemW(n_memw),
        .Branch(n_br), .AdrSrc(n_adr), .ALUOp(n_aluop), .ResultSrc(n_res),
        .ALUSrcA(n_sa), .ALUSrcB(n_sb), .mul_start(n_mst), .bus_err(n_berr),
        .state_o(n_state)
    );

    mainfsm_hs #(.MUL_EN(1'b1), .MEM_HS(1'b1), .TIMEOUT(4)) u_to4 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .is_mul(is_mul),
        .mem_ready(mem_ready), .mul_done(mul_done),
        .IRWrite(t_irw), .NextPC(t_npc), .RegW(t_regw), .MemW(t_memw),
        .Branch(t_br), .AdrSrc(t_adr), .ALUOp(t_aluop), .ResultSrc(t_res),
        .ALUSrcA(t_sa), .ALUSrcB(t_sb), .mul_start(t_mst), .bus_err(t_berr),
        .state_o(t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves every instance in FETCH, one time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        Op = 2'b00; Funct = 6'b0; is_mul = 1'b0; mem_ready = 1'b1; mul_done = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (m_state !== 4'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", m_state); end
        n_checks++; if (m_irw !== 1'b0) begin n_bad++; $display("FAIL reset_irwrite got=%b exp=0", m_irw); end
        n_checks++; if (m_npc !== 1'b0) begin n_bad++; $display("FAIL reset_nextpc got=%b exp=0", m_npc); end
        n_checks++; if (m_mst !== 1'b0 || m_berr !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got=%b%b exp=00", m_mst, m_berr); end
        n_checks++; if (n_state !== 4'd0 || t_state !== 4'd0) begin n_bad++; $display("FAIL reset_state_others got=%0d,%0d exp=0,0", n_state, t_state); end
        reset = 1'b0;
        #1;
        n_checks++; if (m_irw !== 1'b1 || m_npc !== 1'b1) begin n_bad++; $display("FAIL fetch_irwrite got=%b%b exp=11", m_irw, m_npc); end
    endtask

    task automatic test_add();
        int st[5] = '{0, 1, 6, 8, 0};
        do_reset();
        Op = 2'b00; Funct = 6'b000000; is_mul = 1'b0; mem_ready = 1'b1; mul_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (m_state !== 4'(st[i])) begin n_bad++; $display("FAIL add_state c%0d got=%0d exp=%0d", i, m_state, st[i]); end
            n_checks++; if (m_regw !== (st[i] == 8)) begin n_bad++; $display("FAIL add_regw c%0d got=%b exp=%b", i, m_regw, st[i] == 8); end
            if (st[i] == 8) begin
                n_checks++; if (m_res !== 2'b00) begin n_bad++; $display("FAIL add_ressrc got=%b exp=00", m_res); end
            end
            if (st[i] == 6) begin
                n_checks++; if (m_aluop !== 1'b1 || m_sa !== 2'b00 || m_sb !== 2'b00) begin n_bad++; $display("FAIL add_exec got=%b/%b/%b exp=1/00/00", m_aluop, m_sa, m_sb); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_branch();
        int st_i[5] = '{0, 1, 7, 8, 0};
        int st_b[4] = '{0, 1, 9, 0};
        do_reset();
        Op = 2'b00; Funct = 6'b100000; is_mul = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (m_state !== 4'(st_i[i])) begin n_bad++; $display("FAIL addi_state c%0d got=%0d exp=%0d", i, m_state, st_i[i]); end
            if (st_i[i] == 7) begin
                n_checks++; if (m_sb !== 2'b01 || m_aluop !== 1'b1) begin n_bad++; $display("FAIL addi_srcb got=%b/%b exp=01/1", m_sb, m_aluop); end
            end
            @(posedge clk); #1;
        end
        Op = 2'b10; Funct = 6'b0;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (m_state !== 4'(st_b[i])) begin n_bad++; $display("FAIL br_state c%0d got=%0d exp=%0d", i, m_state, st_b[i]); end
            n_checks++; if (m_br !== (st_b[i] == 9)) begin n_bad++; $display("FAIL br_branch c%0d got=%b exp=%b", i, m_br, st_b[i] == 9); end
            if (st_b[i] == 9) begin
                n_checks++; if (m_res !== 2'b10 || m_sb !== 2'b01 || m_sa !== 2'b00) begin n_bad++; $display("FAIL br_sel got=%b/%b/%b exp=10/00/01", m_res, m_sa, m_sb); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ldr_wait();
        int     st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic   mr[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        do_reset();
        Op = 2'b01; Funct = 6'b100001; is_mul = 1'b0; mul_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++; if (m_state !== 4'(st[i])) begin n_bad++; $display("FAIL ldr_state c%0d got=%0d exp=%0d", i, m_state, st[i]); end
            n_checks++; if (m_regw !== (st[i] == 4)) begin n_bad++; $display("FAIL ldr_regw c%0d got=%b exp=%b", i, m_regw, st[i] == 4); end
            if (st[i] == 3) begin
                n_checks++; if (m_adr !== 1'b1) begin n_bad++; $display("FAIL ldr_adrsrc c%0d got=%b exp=1", i, m_adr); end
            end
            if (st[i] == 4) begin
                n_checks++; if (m_res !== 2'b01) begin n_bad++; $display("FAIL ldr_ressrc got=%b exp=01", m_res); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_str_nohs();
        int st[5] = '{0, 1, 2, 5, 0};
        do_reset();
        Op = 2'b01; Funct = 6'b000000; is_mul = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (n_state !== 4'(st[i])) begin n_bad++; $display("FAIL str_state c%0d got=%0d exp=%0d", i, n_state, st[i]); end
            n_checks++; if (n_memw !== (i == 3)) begin n_bad++; $display("FAIL str_memw c%0d got=%b exp=%b", i, n_memw, i == 3); end
            if (i == 0) begin
                n_checks++; if (n_irw !== 1'b1) begin n_bad++; $display("FAIL str_irwrite got=%b exp=1", n_irw); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        int   st[10] = '{0, 1, 11, 12, 12, 12, 12, 12, 13, 0};
        int   sn[5]  = '{0, 1, 6, 8, 0};
        logic md[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        do_reset();
        Op = 2'b00; Funct = 6'b000000; is_mul = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mul_done = md[i];
            #1;
            n_checks++; if (m_state !== 4'(st[i])) begin n_bad++; $display("FAIL mul_state c%0d got=%0d exp=%0d", i, m_state, st[i]); end
            n_checks++; if (m_mst !== (st[i] == 11)) begin n_bad++; $display("FAIL mul_start c%0d got=%b exp=%b", i, m_mst, st[i] == 11); end
            n_checks++; if (m_regw !== (st[i] == 13)) begin n_bad++; $display("FAIL mul_regw c%0d got=%b exp=%b", i, m_regw, st[i] == 13); end
            if (st[i] == 13) begin
                n_checks++; if (m_res !== 2'b11) begin n_bad++; $display("FAIL mul_ressrc got=%b exp=11", m_res); end
            end
            if (i < 5) begin
                n_checks++; if (n_state !== 4'(sn[i])) begin n_bad++; $display("FAIL mul_disabled c%0d got=%0d exp=%0d", i, n_state, sn[i]); end
            end
            @(posedge clk); #1;
        end
        is_mul = 1'b0; mul_done = 1'b0;
    endtask

    task automatic test_timeout();
        int   st[6] = '{0, 0, 0, 0, 10, 0};
        int   sw[5] = '{0, 0, 0, 0, 1};
        logic mr[5] = '{0, 0, 0, 1, 1};
        do_reset();
        Op = 2'b00; Funct = 6'b0; is_mul = 1'b0; mul_done = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (t_state !== 4'(st[i])) begin n_bad++; $display("FAIL to_state c%0d got=%0d exp=%0d", i, t_state, st[i]); end
            n_checks++; if (t_berr !== (i == 3)) begin n_bad++; $display("FAIL to_buserr c%0d got=%b exp=%b", i, t_berr, i == 3); end
            n_checks++; if (t_irw !== 1'b0 || t_npc !== 1'b0) begin n_bad++; $display("FAIL to_irwrite c%0d got=%b%b exp=00", i, t_irw, t_npc); end
            n_checks++; if (m_berr !== 1'b0) begin n_bad++; $display("FAIL to_long_buserr c%0d got=%b exp=0", i, m_berr); end
            @(posedge clk); #1;
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++; if (t_state !== 4'(sw[i])) begin n_bad++; $display("FAIL to_race_state c%0d got=%0d exp=%0d", i, t_state, sw[i]); end
            n_checks++; if (t_berr !== 1'b0) begin n_bad++; $display("FAIL to_race_buserr c%0d got=%b exp=0", i, t_berr); end
            if (i == 3) begin
                n_checks++; if (t_irw !== 1'b1) begin n_bad++; $display("FAIL to_race_irwrite got=%b exp=1", t_irw); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unknown();
        int         st[4] = '{0, 1, 10, 0};
        logic [17:0] ctl;
        do_reset();
        Op = 2'b11; Funct = 6'b111111; is_mul = 1'b1; mem_ready = 1'b1; mul_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (m_state !== 4'(st[i])) begin n_bad++; $display("FAIL ill_state c%0d got=%0d exp=%0d", i, m_state, st[i]); end
            if (st[i] == 10) begin
                ctl = {m_irw, m_npc, m_regw, m_memw, m_br, m_adr, m_aluop, m_res, m_sa, m_sb, m_mst, m_berr, 3'b000};
                n_checks++; if (ctl !== 18'd0) begin n_bad++; $display("FAIL ill_controls got=%b exp=0", ctl); end
            end
            @(posedge clk); #1;
        end
        is_mul = 1'b0;
    endtask

    task automatic test_reset_in_store();
        int   st[4] = '{0, 1, 2, 5};
        logic mr[4] = '{1, 1, 1, 0};
        do_reset();
        Op = 2'b01; Funct = 6'b000000; is_mul = 1'b0; mul_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++; if (m_state !== 4'(st[i])) begin n_bad++; $display("FAIL rst_st_state c%0d got=%0d exp=%0d", i, m_state, st[i]); end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        n_checks++; if (m_memw !== 1'b1) begin n_bad++; $display("FAIL rst_st_memw_before got=%b exp=1", m_memw); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (m_memw !== 1'b0) begin n_bad++; $display("FAIL rst_st_memw_after got=%b exp=0", m_memw); end
        n_checks++; if (m_state !== 4'd0) begin n_bad++; $display("FAIL rst_st_state_after got=%0d exp=0", m_state); end
        n_checks++; if (m_regw !== 1'b0 || m_irw !== 1'b0) begin n_bad++; $display("FAIL rst_st_others got=%b%b exp=00", m_regw, m_irw); end
        @(posedge clk); #1;
        n_checks++; if (m_memw !== 1'b0 || m_state !== 4'd0) begin n_bad++; $display("FAIL rst_st_held got=%b/%0d exp=0/0", m_memw, m_state); end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'b00; Funct = 6'b0; is_mul = 1'b0; mem_ready = 1'b1; mul_done = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_addi_branch();
        test_ldr_wait();
        test_str_nohs();
        test_mul();
        test_timeout();
        test_unknown();
        test_reset_in_store();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mainfsm_hs.md
# mainfsm_hs

Parametrised multicycle-CPU main control FSM with memory ready/wait handshaking, a multi-cycle multiply path and a bus-timeout watchdog. Sits in the controller beside the ALU decoder and PC/branch logic. It consumes decoded Op/Funct plus handshake inputs and drives the datapath enables and mux selects. With MUL_EN=0 and MEM_HS=0 it behaves as the legacy single-latency FSM.

## Interface
- MUL_EN, 1, enables MULSTART/MULWAIT/MULWB path; 0 → is_mul ignored
- MEM_HS, 1, honour mem_ready; 0 → mem_ready treated as constant 1
- TIMEOUT, 16, max cycles spent in any wait state before bus error; 0 disables watchdog
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Op  in  2  instruction class (00 data-proc, 01 memory, 10 branch, 11 illegal)
- Funct  in  6  Funct[5]=immediate, Funct[0]=load(1)/store(0)
- is_mul  in  1  decoder flag: data-proc instruction is MUL
- mem_ready  in  1  memory completes the current access this cycle
- mul_done  in  1  multiplier result valid this cycle
- IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp  out  1 each  datapath controls
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult, 11 MulResult
- ALUSrcA  out  2  00 register A, 01 PC
- ALUSrcB  out  2  00 register B, 01 ExtImm, 10 constant 4
- mul_start  out  1  one-cycle multiply launch
- bus_err  out  1  one-cycle pulse on watchdog expiry
- state_o  out  4  current state, debug

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, UNKNOWN 10, MULSTART 11, MULWAIT 12, MULWB 13.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=rdy. Go to DECODE when rdy, else stay. rdy = mem_ready|~MEM_HS.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Op=00: is_mul&MUL_EN → MULSTART; Funct[5] → EXECUTEI; else EXECUTER.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → UNKNOWN.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 → ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 → ALUWB.
- ALUWB: RegW=1, ResultSrc=00 → FETCH.
- MEMADR: ALUSrcA=00, ALUSrcB=01 → MEMREAD if Funct[0], else MEMWRITE.
- MEMREAD: AdrSrc=1. Stay until rdy, then → MEMWB.
- MEMWB: RegW=1, ResultSrc=01 → FETCH.
- MEMWRITE: AdrSrc=1, MemW=1 held every cycle until rdy, then → FETCH.
- BRANCH: Branch=1, ALUSrcA=00, ALUSrcB=01, ResultSrc=10 → FETCH.
- MULSTART: mul_start=1 → MULWAIT.
- MULWAIT: stay until mul_done, then → MULWB.
- MULWB: RegW=1, ResultSrc=11 → FETCH.
- UNKNOWN: all controls 0 → FETCH.
- Any unlisted state: all controls 0 → FETCH. No X outputs in any state.
- Watchdog: counter clears on every state change and counts each cycle spent in a wait state (FETCH, MEMREAD, MEMWRITE, MULWAIT) while its condition is unmet.
  - When the count reaches TIMEOUT, pulse bus_err and go to UNKNOWN. In that cycle IRWrite/NextPC/MemW are forced 0.
  - A condition met on the same cycle the count reaches TIMEOUT wins: normal transition, no bus_err.

## Timing
- All outputs are Moore-decoded from state, except IRWrite/NextPC, which are gated by rdy.
- Reset: state=FETCH, counter=0, bus_err=0, mul_start=0. IRWrite=NextPC=0 while reset is high.
- Reset asserted mid-instruction aborts it immediately; no RegW/MemW pulse after the reset edge.
- Zero-wait latencies (cycles): data-proc 4, branch 3, load 5, store 4, MUL 4+N where N = cycles until mul_done.
- Each extra cycle of mem_ready=0 adds exactly one cycle.
- mul_done asserted in the MULSTART cycle is ignored; only MULWAIT samples it.
- Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.

## Structure
- Package mainfsm_pkg holds the state localparams, the ResultSrc/ALUSrcA/ALUSrcB encodings and the Op class codes. The ALU decoder shares the package.
- Sub-module wait_timer (parameter TIMEOUT; inputs clr, en; output expired) implements the watchdog.
- The FSM itself is three blocks: state register, next-state logic, output decode.

## Test plan
- Reset, then ADD register with mem_ready=1 → states 0,1,6,8,0; RegW only in cycle 4 with ResultSrc=00.
- LDR with mem_ready low for 3 cycles in MEMREAD → 3 extra MEMREAD cycles; then MEMWB with RegW=1, ResultSrc=01; total 8 cycles.
- STR with MEM_HS=0 and mem_ready=0 → MemW=1 for exactly one cycle; back in FETCH at cycle 4.
- MUL with mul_done after 5 cycles in MULWAIT → mul_start single pulse; MULWB with RegW=1, ResultSrc=11; no RegW earlier.
- TIMEOUT=4, mem_ready stuck 0 in FETCH → bus_err pulses at the 4th wait cycle; UNKNOWN then FETCH; IRWrite never asserted.
- Op=11 → UNKNOWN with all controls 0 → FETCH. Reset asserted during MEMWRITE → MemW drops in the same cycle and state_o=0.
